tetris_move_scheduler: RTL and testbench
========================================

Name: tetris_move_scheduler

Overview:
Sequences the Tetris game datapath. It converts keyboard level signals (left/right/up/down) and an internal gravity timer into single-transfer move commands on a valid/ready handshake into the game-control datapath. Per-key request flags are arbitrated so gravity is never starved. The gravity period is derived from the current score. The block halts all command generation once the game reports failure.

Parameters:
GRAVITY_BASE, 50000000, gravity period in clk cycles at level 0
GRAVITY_STEP, 2000000, period reduction per level
GRAVITY_MIN, 5000000, floor on the gravity period
SOFT_PERIOD, 2500000, gravity period while down is held
REPEAT_DELAY, 15000000, hold time before horizontal auto-repeat begins
REPEAT_RATE, 5000000, auto-repeat interval after REPEAT_DELAY

Ports:
clk  in  1  system clock; all state on rising edge
clrn  in  1  asynchronous active-low reset
left  in  1  level, key held (synchronous to clk)
right  in  1  level, key held
up  in  1  level, rotate key held
down  in  1  level, soft-drop key held
score  in  7  current score from game datapath
fail  in  1  game-over flag, level
cmd_valid  out  1  command offered
cmd  out  3  1=LEFT 2=RIGHT 3=ROTATE 4=DROP; 0 when idle
cmd_ready  in  1  datapath accepts cmd this cycle
level  out  4  score[6:3], registered

Behaviour:
- Reset (clrn=0, async):
  - cmd_valid=0, cmd=0, level=0.
  - All pending flags, edge registers and counters are 0.
  - FSM state is IDLE.
- Edge detect: previous-value registers per key; rise = key & ~prev.
- Left/right conflict: while left&right are both high, no horizontal events fire and the repeat counters are held at 0.
- Horizontal auto-repeat, per key:
  - A rise sets that key's pending flag and clears its hold counter.
  - While the key is held, the hold counter increments.
  - At hold count REPEAT_DELAY-1 an event fires.
  - Thereafter an event fires every REPEAT_RATE cycles.
  - Release clears the counter.
- Rotate fires on rise of up only; it never repeats.
- Gravity period:
  - P = max(GRAVITY_BASE - level*GRAVITY_STEP, GRAVITY_MIN), 32-bit unsigned; clamp before underflow.
  - If down is held, P = min(P, SOFT_PERIOD).
  - The gravity counter increments each cycle. When counter >= P-1, the DROP pending flag is set and the counter resets to 0.
  - A rise of down resets the gravity counter to 0.
  - A mid-count change of P (score or down) takes effect immediately; if counter >= new P-1, the event fires that cycle.
- Pending flags:
  - One bit each for LEFT, RIGHT, ROTATE and DROP.
  - Set on event; a repeat event while already pending merges (no queueing).
  - Cleared in the cycle its command transfers. A set and a clear of the same flag in one cycle leaves it set.
- FSM:
  - IDLE: if any flag is pending and fail=0, go to ISSUE and load cmd by priority DROP > ROTATE > LEFT > RIGHT.
  - ISSUE: cmd_valid=1 and cmd is held stable until cmd_valid&cmd_ready, then clear that flag and return to IDLE. Back-to-back issue is not permitted: at least one IDLE cycle separates transfers.
  - HALT: entered from any state when fail=1. cmd_valid=0, cmd=0, all flags cleared, counters held at 0. This is the sole exception to the hold-until-ready rule. Exit from HALT is by reset only.
- Latency: a key sampled high at edge k sets its flag at edge k; cmd_valid is high after edge k+1 (if IDLE and nothing of higher priority is pending).
- level register updates every cycle from score.

Test Plan:
Sim parameters for all scenarios: GRAVITY_BASE=100, STEP=10, MIN=20, SOFT_PERIOD=5, REPEAT_DELAY=30, REPEAT_RATE=8.

1. Reset, score=0, no keys, cmd_ready=1 -> first DROP transfer 100 cycles after reset release, then every 100 cycles (±1 for the IDLE gap rule); cmd=0 whenever cmd_valid=0.
2. Left held 60 cycles, cmd_ready=1 -> LEFT transfers at press+2, press+31, press+39, press+47, press+55; none after release.
3. Up held 50 cycles -> exactly one ROTATE. Left&right held together 50 cycles -> zero LEFT/RIGHT commands.
4. cmd_ready=0 with left press and a gravity event pending -> cmd=DROP held stable with valid high. Five further left presses during the stall merge. After cmd_ready=1 the order is DROP, then a single LEFT.
5. score=7'd72 (level 9) -> P=max(100-90,20)=20, DROPs every 20 cycles. Then down held -> DROPs every 5 cycles, and the counter restarts at the down rise.
6. fail asserted while cmd_valid=1 and cmd_ready=0 -> next cycle cmd_valid=0, cmd=0, no commands thereafter despite keys. Pulse clrn=0 -> outputs reset, gravity resumes.

Source files
------------

// File: rtl/tetris_move_scheduler_if.sv
// Single-transfer command handshake from the move scheduler into the game-control datapath.
interface tetris_move_scheduler_if;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd, input cmd_ready);
   modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_move_scheduler.sv
// Turns key levels and score-driven gravity into LEFT/RIGHT/ROTATE/DROP commands,
// one per handshake, with sticky per-command pending flags and a halt on game over.
module tetris_move_scheduler #(
   parameter int unsigned GRAVITY_BASE = 50000000,
   parameter int unsigned GRAVITY_STEP = 2000000,
   parameter int unsigned GRAVITY_MIN  = 5000000,
   parameter int unsigned SOFT_PERIOD  = 2500000,
   parameter int unsigned REPEAT_DELAY = 15000000,
   parameter int unsigned REPEAT_RATE  = 5000000
) (
   input  logic                    clk,
   input  logic                    clrn,
   input  logic                    left,
   input  logic                    right,
   input  logic                    up,
   input  logic                    down,
   input  logic [6:0]              score,
   input  logic                    fail,
   output logic [3:0]              level,
   tetris_move_scheduler_if.master cmd_if
);
   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_LEFT  = 3'd1;
   localparam logic [2:0] CMD_RIGHT = 3'd2;
   localparam logic [2:0] CMD_ROT   = 3'd3;
   localparam logic [2:0] CMD_DROP  = 3'd4;

   localparam logic [31:0] G_BASE   = 32'(GRAVITY_BASE);
   localparam logic [31:0] G_STEP   = 32'(GRAVITY_STEP);
   localparam logic [31:0] G_MIN    = 32'(GRAVITY_MIN);
   localparam logic [31:0] G_SOFT   = 32'(SOFT_PERIOD);
   localparam logic [31:0] RPT_FIRE = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] RPT_WRAP = 32'(REPEAT_DELAY + REPEAT_RATE - 2);

   typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cmd_q, cmd_nxt, prio;
   logic [3:0]  pend, pend_nxt, pend_set, pend_clr;   // {DROP, ROT, RIGHT, LEFT}
   logic        prev_l, prev_r, prev_u, prev_d;
   logic [31:0] hcnt_l, hcnt_r, hcnt_l_nxt, hcnt_r_nxt;
   logic [31:0] gcnt, gcnt_nxt, lvl_drop, per_lvl, per;
   logic        ev_l, ev_r, ev_u, ev_g;
   logic        halt, conflict, xfer;
   logic        unused_score;

   assign unused_score = ^score[2:0];

   // Past the initial delay the counter cycles through [FIRE, WRAP], firing on each entry to FIRE.
   function automatic logic [32:0] h_step(input logic key, input logic prev,
                                          input logic [31:0] cnt);
      logic [31:0] inc;
      inc = (cnt == RPT_WRAP) ? RPT_FIRE : cnt + 32'd1;
      if (!key || !prev) h_step = {key & ~prev, 32'd0};
      else               h_step = {inc == RPT_FIRE, inc};
   endfunction

   assign halt     = fail | (state == HALT);
   assign conflict = left & right;
   assign xfer     = (state == ISSUE) & cmd_if.cmd_ready;

   always_comb begin
      {ev_l, hcnt_l_nxt} = h_step(left,  prev_l, hcnt_l);
      {ev_r, hcnt_r_nxt} = h_step(right, prev_r, hcnt_r);
      if (halt || conflict) begin
         {ev_l, hcnt_l_nxt} = 33'd0;
         {ev_r, hcnt_r_nxt} = 33'd0;
      end
      ev_u = up & ~prev_u & ~halt;
   end

   // Period is recomputed every cycle, so score or down changes apply mid-count.
   always_comb begin
      lvl_drop = 32'(level) * G_STEP;
      per_lvl  = ({1'b0, lvl_drop} + {1'b0, G_MIN} >= {1'b0, G_BASE}) ? G_MIN
                                                                     : G_BASE - lvl_drop;
      per      = (down && per_lvl > G_SOFT) ? G_SOFT : per_lvl;
      ev_g     = 1'b0;
      gcnt_nxt = gcnt + 32'd1;
      if (halt || (down && !prev_d)) begin
         gcnt_nxt = 32'd0;
      end else if (gcnt >= per - 32'd1) begin
         ev_g     = 1'b1;
         gcnt_nxt = 32'd0;
      end
   end

   always_comb begin
      pend_set = {ev_g, ev_u, ev_r, ev_l};
      pend_clr = xfer ? 4'(4'b0001 << (cmd_q - 3'd1)) : 4'b0000;
      pend_nxt = halt ? 4'b0000 : ((pend & ~pend_clr) | pend_set);
      prio     = CMD_RIGHT;
      if (pend[0]) prio = CMD_LEFT;
      if (pend[2]) prio = CMD_ROT;
      if (pend[3]) prio = CMD_DROP;
   end

   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd_q;
      if (fail) begin
         state_nxt = HALT;
         cmd_nxt   = CMD_NONE;
      end else begin
         case (state)
            IDLE: if (|pend) begin
               state_nxt = ISSUE;
               cmd_nxt   = prio;
            end
            ISSUE: if (cmd_if.cmd_ready) begin
               state_nxt = IDLE;
               cmd_nxt   = CMD_NONE;
            end
            default: begin
               state_nxt = HALT;
               cmd_nxt   = CMD_NONE;
            end
         endcase
      end
   end

   assign cmd_if.cmd_valid = (state == ISSUE);
   assign cmd_if.cmd       = cmd_q;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state  <= IDLE;
         cmd_q  <= CMD_NONE;
         pend   <= 4'b0000;
         prev_l <= 1'b0;
         prev_r <= 1'b0;
         prev_u <= 1'b0;
         prev_d <= 1'b0;
         hcnt_l <= 32'd0;
         hcnt_r <= 32'd0;
         gcnt   <= 32'd0;
         level  <= 4'd0;
      end else begin
         state  <= state_nxt;
         cmd_q  <= cmd_nxt;
         pend   <= pend_nxt;
         prev_l <= left;
         prev_r <= right;
         prev_u <= up;
         prev_d <= down;
         hcnt_l <= hcnt_l_nxt;
         hcnt_r <= hcnt_r_nxt;
         gcnt   <= gcnt_nxt;
         level  <= score[6:3];
      end
   end
endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Bench for tetris_move_scheduler: directed scenarios with fixed transfer times plus
// randomized keys/score/ready checked every cycle against a behavioural model.
module tb_tetris_move_scheduler;
   localparam int GB = 100, GS = 10, GM = 20, SP = 5, RD = 30, RR = 8;

   logic       clk = 1'b0, clrn = 1'b0;
   logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, fail = 1'b0;
   logic       ready = 1'b1;
   logic [6:0] score = 7'd0;
   logic [3:0] level;

   tetris_move_scheduler_if cmd_if();
   assign cmd_if.cmd_ready = ready;

   tetris_move_scheduler #(
      .GRAVITY_BASE(GB), .GRAVITY_STEP(GS), .GRAVITY_MIN(GM),
      .SOFT_PERIOD(SP), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .clrn(clrn), .left(left), .right(right), .up(up), .down(down),
      .score(score), .fail(fail), .level(level), .cmd_if(cmd_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // m_st: 0 idle, 1 offering m_cmd, 2 halted. hl/hr are cycles held since press.
   int       m_st, m_cmd, m_lvl, hl, hr, gel, cyc;
   bit [3:0] m_pend;
   bit       pl, pr, pu, pd;
   int       log_cyc[$], log_cmd[$];

   function automatic bit rep_hit(input int h);
      return (h == RD - 1) || (h > RD - 1 && (h - (RD - 1)) % RR == 0);
   endfunction

   int       p, old_cmd;
   bit       halt, conf, ev_l, ev_r, ev_u, ev_g, xfer;
   bit [3:0] old_pend;

   always @(posedge clk) begin
      if (!clrn) begin
         m_st = 0; m_cmd = 0; m_lvl = 0; hl = 0; hr = 0; gel = 0; cyc = 0;
         m_pend = 4'b0; pl = 0; pr = 0; pu = 0; pd = 0;
         log_cyc.delete(); log_cmd.delete();
      end else begin
         cyc++;
         if (cmd_if.cmd_valid && ready) begin
            log_cyc.push_back(cyc);
            log_cmd.push_back(int'(cmd_if.cmd));
         end
         halt = (m_st == 2) || fail;
         conf = left && right;
         ev_l = 0; ev_r = 0; ev_g = 0;
         if (halt || conf || !left) hl = 0;
         else if (!pl) begin ev_l = 1; hl = 0; end
         else begin hl++; ev_l = rep_hit(hl); end
         if (halt || conf || !right) hr = 0;
         else if (!pr) begin ev_r = 1; hr = 0; end
         else begin hr++; ev_r = rep_hit(hr); end
         ev_u = up && !pu && !halt;
         p = GB - m_lvl * GS;
         if (p < GM) p = GM;
         if (down && p > SP) p = SP;
         if (halt || (down && !pd)) gel = 0;
         else if (gel + 1 >= p) begin ev_g = 1; gel = 0; end
         else gel++;

         old_pend = m_pend;
         old_cmd  = m_cmd;
         xfer     = (m_st == 1) && ready;
         if (fail) begin m_st = 2; m_cmd = 0; end
         else if (m_st == 0 && old_pend != 0) begin
            m_st  = 1;
            m_cmd = old_pend[3] ? 4 : old_pend[2] ? 3 : old_pend[0] ? 1 : 2;
         end else if (m_st == 1 && ready) begin m_st = 0; m_cmd = 0; end

         if (halt) m_pend = 4'b0;
         else begin
            if (xfer) m_pend[old_cmd - 1] = 1'b0;
            if (ev_l) m_pend[0] = 1'b1;
            if (ev_r) m_pend[1] = 1'b1;
            if (ev_u) m_pend[2] = 1'b1;
            if (ev_g) m_pend[3] = 1'b1;
         end
         pl = left; pr = right; pu = up; pd = down;
         m_lvl = int'(score) / 8;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("valid", int'(cmd_if.cmd_valid), int'(m_st == 1));
         chk("cmd",   int'(cmd_if.cmd),       m_cmd);
         chk("level", int'(level),            m_lvl);
      end
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      #1;
      chk("rst_valid", int'(cmd_if.cmd_valid), 0);
      chk("rst_cmd",   int'(cmd_if.cmd),       0);
      chk("rst_level", int'(level),            0);
      step(2);
      clrn = 1'b1;
   endtask

   task automatic chk_xfer(input string tag, input int idx, input int ecyc, input int ecmd);
      if (idx < log_cyc.size()) begin
         chk({tag, "_cyc"}, log_cyc[idx], ecyc);
         chk({tag, "_cmd"}, log_cmd[idx], ecmd);
      end else chk({tag, "_missing"}, -1, ecyc);
   endtask

   task automatic keys_off();
      left = 0; right = 0; up = 0; down = 0;
   endtask

   task automatic rand_run(input int n, input int fail_at);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(39) == 0) left  = ~left;
         if ($urandom_range(39) == 0) right = ~right;
         if ($urandom_range(29) == 0) up    = ~up;
         if ($urandom_range(59) == 0) down  = ~down;
         if ($urandom_range(99) == 0) score = 7'($urandom_range(127));
         ready = ($urandom_range(9) < 7);
         if (i == fail_at) fail = 1'b1;
         step(1);
      end
   endtask

   int n_rot, n_lr;

   initial begin
      @(negedge clk);

      // 1: gravity alone at level 0
      ready = 1; do_reset();
      step(205);
      chk("s1_count", log_cyc.size(), 2);
      chk_xfer("s1_drop0", 0, 102, 4);
      chk_xfer("s1_drop1", 1, 202, 4);

      // 2: left held 60 cycles, press sampled at edge 5
      do_reset();
      step(4); left = 1;
      step(60); left = 0;
      step(31);
      chk("s2_count", log_cyc.size(), 5);
      chk_xfer("s2_l0", 0, 7, 1);
      chk_xfer("s2_l1", 1, 36, 1);
      chk_xfer("s2_l2", 2, 44, 1);
      chk_xfer("s2_l3", 3, 52, 1);
      chk_xfer("s2_l4", 4, 60, 1);

      // 3: rotate never repeats; left+right together is suppressed
      do_reset();
      step(4); up = 1;
      step(50); up = 0; left = 1; right = 1;
      step(50); keys_off();
      step(5);
      n_rot = 0; n_lr = 0;
      foreach (log_cmd[i]) begin
         if (log_cmd[i] == 3) n_rot++;
         if (log_cmd[i] == 1 || log_cmd[i] == 2) n_lr++;
      end
      chk("s3_rotates", n_rot, 1);
      chk("s3_horiz", n_lr, 0);

      // 4: stall with DROP offered, left presses merge
      ready = 0; do_reset();
      step(104);
      repeat (5) begin left = 1; step(2); left = 0; step(2); end
      step(6);
      chk("s4_hold_valid", int'(cmd_if.cmd_valid), 1);
      chk("s4_hold_cmd", int'(cmd_if.cmd), 4);
      ready = 1;
      step(10);
      chk("s4_count", log_cyc.size(), 2);
      chk_xfer("s4_first", 0, 131, 4);
      chk_xfer("s4_second", 1, 133, 1);

      // 5: level 9 gravity, then soft drop restarting at the down rise
      score = 7'd72; do_reset();
      step(69); down = 1;
      step(21); down = 0;
      chk("s5_count", log_cyc.size(), 6);
      chk_xfer("s5_d0", 0, 22, 4);
      chk_xfer("s5_d1", 1, 42, 4);
      chk_xfer("s5_d2", 2, 62, 4);
      chk_xfer("s5_d3", 3, 77, 4);
      chk_xfer("s5_d4", 4, 82, 4);
      chk_xfer("s5_d5", 5, 87, 4);

      // 6: fail during a stalled offer, then recovery by reset
      score = 7'd0; ready = 0; do_reset();
      step(4); left = 1;
      step(5); fail = 1;
      step(1);
      chk("s6_halt_valid", int'(cmd_if.cmd_valid), 0);
      chk("s6_halt_cmd", int'(cmd_if.cmd), 0);
      ready = 1; left = 0;
      for (int i = 0; i < 40; i++) begin
         left = i[2]; up = i[3]; down = i[1];
         step(3);
      end
      fail = 0; keys_off();
      step(150);
      chk("s6_halted_xfers", log_cyc.size(), 0);
      do_reset();
      step(105);
      chk("s6_resume_count", log_cyc.size(), 1);
      chk_xfer("s6_resume", 0, 102, 4);

      // randomized runs, the second ending in game over
      keys_off(); do_reset();
      rand_run(2000, -1);
      keys_off(); score = 7'd0; do_reset();
      rand_run(2000, 1500);
      fail = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 0, expected 1 (bench did not complete)");
      $fatal(1);
   end
endmodule
